// File: rtl/freelist_ckpt.sv
// freelist_ckpt -- physical-register free list with branch checkpoints.
//
// A circular queue of DEPTH = PRF_NUM-ARCH_NUM free physical register
// indices. Rename pops up to ALLOC_W entries per cycle from head, commit
// pushes up to FREE_W entries per cycle at tail. A circular buffer of
// CKPT_NUM head snapshots supports branch recovery; a flush restores head
// to the retired position (retire_head).
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   alloc_req/mask    rename allocation request and per-slot need mask
//   alloc_ready       allocation can be granted this cycle
//   alloc_preg        granted indices, slot i at [i*PW +: PW] (0 if unmasked)
//   free_valid/mask   commit free request and per-slot valid mask
//   free_preg         freed indices, slot i at [i*PW +: PW]
//   retire_num        allocations retired this cycle
//   ckpt_take/ready   snapshot request / a checkpoint slot is free
//   ckpt_id           id assigned to a ckpt_take this cycle
//   ckpt_release      release oldest checkpoint
//   recover_valid/id  branch mispredict, restore head to snapshot recover_id
//   flush_valid       exception, restore head to retired state
//   free_count        free entries; empty/full derived from it
//   overflow          sticky: a free arrived with no room
module freelist_ckpt #(
  parameter int PRF_NUM  = 64,
  parameter int ARCH_NUM = 32,
  parameter int ALLOC_W  = 4,
  parameter int FREE_W   = 4,
  parameter int CKPT_NUM = 4
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   alloc_req,
  input  logic [ALLOC_W-1:0]                     alloc_mask,
  output logic                                   alloc_ready,
  output logic [ALLOC_W*$clog2(PRF_NUM)-1:0]     alloc_preg,
  input  logic                                   free_valid,
  input  logic [FREE_W-1:0]                      free_mask,
  input  logic [FREE_W*$clog2(PRF_NUM)-1:0]      free_preg,
  input  logic [$clog2(ALLOC_W+1)-1:0]           retire_num,
  input  logic                                   ckpt_take,
  output logic                                   ckpt_ready,
  output logic [$clog2(CKPT_NUM)-1:0]            ckpt_id,
  input  logic                                   ckpt_release,
  input  logic                                   recover_valid,
  input  logic [$clog2(CKPT_NUM)-1:0]            recover_id,
  input  logic                                   flush_valid,
  output logic [$clog2(PRF_NUM-ARCH_NUM):0]      free_count,
  output logic                                   empty,
  output logic                                   full,
  output logic                                   overflow
);

  localparam int DEPTH = PRF_NUM - ARCH_NUM;
  localparam int PW    = $clog2(PRF_NUM);
  localparam int PTRW  = $clog2(DEPTH) + 1;
  localparam int IW    = PTRW - 1;
  localparam int CW    = $clog2(CKPT_NUM);
  localparam int CNTW  = $clog2(CKPT_NUM + 1);

  logic [PW-1:0]   queue [DEPTH];
  logic [PTRW-1:0] head;
  logic [PTRW-1:0] tail;
  logic [PTRW-1:0] retire_head;

  logic [PTRW-1:0] snap [CKPT_NUM];
  logic [CW-1:0]   ck_wr;
  logic [CW-1:0]   ck_rd;
  logic [CNTW-1:0] ck_cnt;

  logic [PTRW-1:0] alloc_cnt;
  logic            alloc_fire;
  logic [PTRW-1:0] head_alloc;

  logic [PTRW-1:0] room;
  logic [PTRW-1:0] free_req;
  logic [PTRW-1:0] free_acc;
  logic            free_drop;
  logic [FREE_W-1:0] wr_en;
  logic [IW-1:0]   wr_idx [FREE_W];

  logic            take_fire;
  logic            rel_fire;
  logic [CW-1:0]   ck_span;

  assign free_count = tail - head;
  assign empty      = (free_count == '0);
  assign full       = (free_count == PTRW'(DEPTH));

  // Allocation: the k-th set mask bit reads queue[head+k].
  always_comb begin
    alloc_cnt  = '0;
    alloc_preg = '0;
    for (int unsigned i = 0; i < ALLOC_W; i++) begin
      if (alloc_mask[i]) begin
        alloc_preg[i*PW +: PW] = queue[head[IW-1:0] + alloc_cnt[IW-1:0]];
        alloc_cnt = alloc_cnt + PTRW'(1);
      end
    end
  end

  assign alloc_ready = (free_count >= alloc_cnt) && !recover_valid && !flush_valid;
  assign alloc_fire  = alloc_req && alloc_ready;
  assign head_alloc  = alloc_fire ? (head + alloc_cnt) : head;

  // Frees: room is judged against registered pointers, so entries
  // allocated this same cycle do not make space for this cycle's frees.
  assign room = PTRW'(DEPTH) - free_count;

  always_comb begin
    free_req = '0;
    free_acc = '0;
    wr_en    = '0;
    for (int unsigned i = 0; i < FREE_W; i++) begin
      wr_idx[i] = '0;
      if (free_valid && free_mask[i]) begin
        if (free_req < room) begin
          wr_en[i]  = 1'b1;
          wr_idx[i] = tail[IW-1:0] + free_req[IW-1:0];
          free_acc  = free_acc + PTRW'(1);
        end
        free_req = free_req + PTRW'(1);
      end
    end
  end

  assign free_drop = (free_req != free_acc);

  // Checkpoint bookkeeping.
  assign ckpt_ready = (ck_cnt < CNTW'(CKPT_NUM));
  assign ckpt_id    = ck_wr;
  assign take_fire  = ckpt_take && ckpt_ready;
  assign rel_fire   = ckpt_release && (ck_cnt != '0);
  assign ck_span    = recover_id - ck_rd;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        queue[i] <= PW'(ARCH_NUM + int'(i));
      end
    end else begin
      for (int unsigned i = 0; i < FREE_W; i++) begin
        if (wr_en[i]) queue[wr_idx[i]] <= free_preg[i*PW +: PW];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !flush_valid && !recover_valid && take_fire) begin
      snap[ck_wr] <= head_alloc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head        <= '0;
      retire_head <= '0;
      tail        <= PTRW'(DEPTH);
      ck_wr       <= '0;
      ck_rd       <= '0;
      ck_cnt      <= '0;
      overflow    <= 1'b0;
    end else begin
      tail        <= tail + free_acc;
      retire_head <= retire_head + PTRW'(retire_num);
      if (free_drop) overflow <= 1'b1;

      if (flush_valid) begin
        head   <= retire_head + PTRW'(retire_num);
        ck_wr  <= '0;
        ck_rd  <= '0;
        ck_cnt <= '0;
      end else if (recover_valid) begin
        // Live set becomes oldest..recover_id inclusive, minus any release.
        head   <= snap[recover_id];
        ck_wr  <= recover_id + CW'(1);
        ck_rd  <= ck_rd + CW'(rel_fire);
        ck_cnt <= CNTW'(ck_span) + CNTW'(1) - CNTW'(rel_fire);
      end else begin
        head   <= head_alloc;
        if (take_fire) ck_wr <= ck_wr + CW'(1);
        ck_rd  <= ck_rd + CW'(rel_fire);
        ck_cnt <= ck_cnt + CNTW'(take_fire) - CNTW'(rel_fire);
      end
    end
  end

endmodule

// File: tb/tb_freelist_ckpt.sv
module tb_freelist_ckpt;

  localparam int PW = 6;

  logic        clk;
  logic        rst;
  logic        alloc_req;
  logic [3:0]  alloc_mask;
  logic        alloc_ready;
  logic [23:0] alloc_preg;
  logic        free_valid;
  logic [3:0]  free_mask;
  logic [23:0] free_preg;
  logic [2:0]  retire_num;
  logic        ckpt_take;
  logic        ckpt_ready;
  logic [1:0]  ckpt_id;
  logic        ckpt_release;
  logic        recover_valid;
  logic [1:0]  recover_id;
  logic        flush_valid;
  logic [5:0]  free_count;
  logic        empty;
  logic        full;
  logic        overflow;

  int total  = 0;
  int passed = 0;

  freelist_ckpt #(
    .PRF_NUM(64), .ARCH_NUM(32), .ALLOC_W(4), .FREE_W(4), .CKPT_NUM(4)
  ) dut (
    .clk(clk), .rst(rst),
    .alloc_req(alloc_req), .alloc_mask(alloc_mask),
    .alloc_ready(alloc_ready), .alloc_preg(alloc_preg),
    .free_valid(free_valid), .free_mask(free_mask), .free_preg(free_preg),
    .retire_num(retire_num),
    .ckpt_take(ckpt_take), .ckpt_ready(ckpt_ready), .ckpt_id(ckpt_id),
    .ckpt_release(ckpt_release),
    .recover_valid(recover_valid), .recover_id(recover_id),
    .flush_valid(flush_valid),
    .free_count(free_count), .empty(empty), .full(full), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  function automatic logic [31:0] slot(input int i);
    return 32'(alloc_preg[i*PW +: PW]);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alloc_req = 0; alloc_mask = '0; free_valid = 0; free_mask = '0;
    free_preg = '0; retire_num = '0; ckpt_take = 0; ckpt_release = 0;
    recover_valid = 0; recover_id = '0; flush_valid = 0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  task automatic alloc4(input int n);
    for (int k = 0; k < n; k++) begin
      alloc_req = 1; alloc_mask = 4'b1111;
      tick();
    end
    idle();
  endtask

  int q[$];
  int a[4];

  initial begin
    rst = 0;
    idle();

    // Reset state
    do_reset();
    #1;
    chk("rst_free_count", 32'(free_count), 32);
    chk("rst_full", 32'(full), 1);
    chk("rst_empty", 32'(empty), 0);
    chk("rst_ckpt_ready", 32'(ckpt_ready), 1);
    chk("rst_ckpt_id", 32'(ckpt_id), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_alloc_preg", 32'(alloc_preg), 0);

    // Sparse mask 1011
    alloc_req = 1; alloc_mask = 4'b1011;
    #1;
    chk("m1011_ready", 32'(alloc_ready), 1);
    chk("m1011_s0", slot(0), 32);
    chk("m1011_s1", slot(1), 33);
    chk("m1011_s2", slot(2), 0);
    chk("m1011_s3", slot(3), 34);
    tick();
    idle();
    chk("m1011_free_count", 32'(free_count), 29);
    alloc_mask = 4'b0001;
    #1;
    chk("m1011_next_head", slot(0), 35);
    idle();

    // Drain to 2, refused request, same-cycle free not bypassed
    do_reset();
    alloc4(7);
    alloc_req = 1; alloc_mask = 4'b0011;
    tick();
    idle();
    chk("drain_free_count", 32'(free_count), 2);
    alloc_req = 1; alloc_mask = 4'b1111;
    free_valid = 1; free_mask = 4'b0011;
    free_preg[0*PW +: PW] = 6'd40;
    free_preg[1*PW +: PW] = 6'd41;
    #1;
    chk("drain_not_ready", 32'(alloc_ready), 0);
    tick();
    idle();
    chk("drain_head_held", 32'(free_count), 4);
    alloc_req = 1; alloc_mask = 4'b1111;
    #1;
    chk("drain_ready_next", 32'(alloc_ready), 1);
    chk("drain_s0", slot(0), 62);
    chk("drain_s1", slot(1), 63);
    chk("drain_s2_wrap", slot(2), 40);
    chk("drain_s3_wrap", slot(3), 41);
    idle();

    // Checkpoint and recover
    do_reset();
    alloc_req = 1; alloc_mask = 4'b1111; ckpt_take = 1;
    #1;
    chk("ck_id0", 32'(ckpt_id), 0);
    tick();
    idle();
    alloc4(1);
    chk("ck_free_count_24", 32'(free_count), 24);
    recover_valid = 1; recover_id = 2'd0;
    alloc_req = 1; alloc_mask = 4'b1111;
    #1;
    chk("ck_recover_blocks_alloc", 32'(alloc_ready), 0);
    tick();
    idle();
    chk("ck_recover_free_count", 32'(free_count), 28);
    chk("ck_recover_ready", 32'(ckpt_ready), 1);
    chk("ck_recover_next_id", 32'(ckpt_id), 1);
    alloc_mask = 4'b0001;
    #1;
    chk("ck_recover_head", slot(0), 36);
    idle();

    // Flush with retire
    do_reset();
    alloc_req = 1; alloc_mask = 4'b1111; ckpt_take = 1;
    tick();
    idle();
    alloc4(1);
    flush_valid = 1; retire_num = 3'd4;
    tick();
    idle();
    chk("fl_free_count", 32'(free_count), 28);
    chk("fl_ckpt_ready", 32'(ckpt_ready), 1);
    alloc_mask = 4'b0001;
    #1;
    chk("fl_head", slot(0), 36);
    idle();
    ckpt_take = 1;
    tick(); tick(); tick();
    idle();
    chk("fl_ck_three_ready", 32'(ckpt_ready), 1);
    ckpt_take = 1;
    tick();
    idle();
    chk("fl_ck_four_full", 32'(ckpt_ready), 0);
    ckpt_release = 1;
    tick();
    idle();
    chk("fl_ck_release", 32'(ckpt_ready), 1);

    // Overflow at full
    do_reset();
    free_valid = 1; free_mask = 4'b0001; free_preg[0*PW +: PW] = 6'd5;
    tick();
    idle();
    chk("ov_overflow", 32'(overflow), 1);
    chk("ov_free_count", 32'(free_count), 32);
    chk("ov_full", 32'(full), 1);
    alloc_mask = 4'b0001;
    #1;
    chk("ov_no_overwrite", slot(0), 32);
    idle();

    // Empty boundary and zero-mask grant
    do_reset();
    alloc4(8);
    chk("emp_free_count", 32'(free_count), 0);
    chk("emp_empty", 32'(empty), 1);
    alloc_req = 1; alloc_mask = 4'b0001;
    #1;
    chk("emp_not_ready", 32'(alloc_ready), 0);
    alloc_mask = 4'b0000;
    #1;
    chk("emp_zero_mask_ready", 32'(alloc_ready), 1);
    tick();
    idle();
    chk("emp_zero_mask_noop", 32'(free_count), 0);

    // Wrap: FIFO order across several pointer wraps
    do_reset();
    q.delete();
    for (int i = 0; i < 32; i++) q.push_back(32 + i);
    for (int it = 0; it < 20; it++) begin
      alloc_req = 1; alloc_mask = 4'b1111;
      #1;
      for (int j = 0; j < 4; j++) begin
        a[j] = q.pop_front();
        chk($sformatf("wrap%0d_s%0d", it, j), slot(j), 32'(a[j]));
      end
      tick();
      idle();
      chk($sformatf("wrap%0d_fc_alloc", it), 32'(free_count), 28);
      free_valid = 1; free_mask = 4'b1111;
      for (int j = 0; j < 4; j++) begin
        free_preg[j*PW +: PW] = PW'(a[(j + 1) % 4]);
        q.push_back(a[(j + 1) % 4]);
      end
      tick();
      idle();
      chk($sformatf("wrap%0d_fc_free", it), 32'(free_count), 32);
    end
    chk("wrap_overflow", 32'(overflow), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
